// File: rtl/connect_four_pkg.sv
// rtl/connect_four_pkg.sv - shared timing defaults and auto-repeat state type
package connect_four_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;
  localparam int REPEAT_DELAY_DEFAULT    = 12500000;
  localparam int REPEAT_RATE_DEFAULT     = 5000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } repeat_state_t;

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchroniser plus debounce counter with press/release event pulses
module button_debouncer
  import connect_four_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_raw_i,
  output logic press_o,
  output logic release_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised level disagrees with stable.
  always_comb begin
    stable_d  = stable_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d  = sync2_q;
        press_d   = sync2_q;
        release_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= btn_raw_i;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/connect_four_input_conditioner.sv
// rtl/connect_four_input_conditioner.sv - debounced, auto-repeating, arbitrated button command strobes
module connect_four_input_conditioner
  import connect_four_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_RATE     = REPEAT_RATE_DEFAULT
) (
  input  logic clk_25MHz,
  input  logic rst_n,
  input  logic btn_right_raw,
  input  logic btn_left_raw,
  input  logic btn_drop_raw,
  output logic move_right,
  output logic move_left,
  output logic drop_piece
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [1:0] btn_raw, press, release_evt, move_strobe;
  logic       drop_press, drop_release_unused;
  logic       move_right_d, move_left_d, drop_piece_d;

  assign btn_raw = {btn_left_raw, btn_right_raw};

  // Index 0 is the right channel, index 1 the left channel.
  for (genvar g = 0; g < 2; g++) begin : g_move
    repeat_state_t   state_q;
    logic [RW-1:0]   cnt_q;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk_i     (clk_25MHz),
      .rst_ni    (rst_n),
      .btn_raw_i (btn_raw[g]),
      .press_o   (press[g]),
      .release_o (release_evt[g])
    );

    // A release in the same cycle as a due repeat wins.
    assign move_strobe[g] = !release_evt[g] &&
                            ((state_q == IDLE   && press[g]) ||
                             (state_q == DELAY  && cnt_q == DELAY_LAST) ||
                             (state_q == REPEAT && cnt_q == RATE_LAST));

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if (press[g]) state_q <= DELAY;
          end
          DELAY: begin
            if (release_evt[g]) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_q == DELAY_LAST) begin
              state_q <= REPEAT;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + RW'(1);
            end
          end
          REPEAT: begin
            if (release_evt[g]) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_q == RATE_LAST) begin
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + RW'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_drop_debounce (
    .clk_i     (clk_25MHz),
    .rst_ni    (rst_n),
    .btn_raw_i (btn_drop_raw),
    .press_o   (drop_press),
    .release_o (drop_release_unused)
  );

  // Drop discards any concurrent move; opposing moves cancel each other.
  always_comb begin
    drop_piece_d = drop_press;
    move_right_d = move_strobe[0] && !move_strobe[1] && !drop_press;
    move_left_d  = move_strobe[1] && !move_strobe[0] && !drop_press;
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      move_right <= 1'b0;
      move_left  <= 1'b0;
      drop_piece <= 1'b0;
    end else begin
      move_right <= move_right_d;
      move_left  <= move_left_d;
      drop_piece <= drop_piece_d;
    end
  end

endmodule

// File: tb/tb_connect_four_input_conditioner.sv
// tb/tb_connect_four_input_conditioner.sv - self-checking bench with a sample-window reference model
module tb_connect_four_input_conditioner;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] raw = 3'b000;   // [0]=right [1]=left [2]=drop
  logic       move_right, move_left, drop_piece;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int q_r[$];
  int q_l[$];
  int q_d[$];

  connect_four_input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
  ) dut (
    .clk_25MHz     (clk),
    .rst_n         (rst_n),
    .btn_right_raw (raw[0]),
    .btn_left_raw  (raw[1]),
    .btn_drop_raw  (raw[2]),
    .move_right    (move_right),
    .move_left     (move_left),
    .drop_piece    (drop_piece)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: stable flips once the D samples preceding the newest
  // synchronised one all disagree with it; strobes are scheduled in absolute edge time.
  bit win [3][D+2];
  bit st [3];
  bit held [2];
  bit first [2];
  int nxt [2];
  bit drop_pend;
  int mt = 0;
  bit exp_r, exp_l, exp_d;

  always @(posedge clk or negedge rst_n) begin
    bit sr, sl, sd, all_diff;
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        for (int i = 0; i < D + 2; i++) win[c][i] = 1'b0;
        st[c] = 1'b0;
      end
      held[0] = 1'b0; held[1] = 1'b0;
      drop_pend = 1'b0;
      exp_r = 1'b0; exp_l = 1'b0; exp_d = 1'b0;
    end else begin
      mt++;
      sr = held[0] && (nxt[0] == mt);
      sl = held[1] && (nxt[1] == mt);
      for (int c = 0; c < 2; c++)
        if (held[c] && nxt[c] == mt) begin
          nxt[c]   = mt + (first[c] ? RD : RR);
          first[c] = 1'b0;
        end
      sd = drop_pend;
      drop_pend = 1'b0;
      for (int c = 0; c < 3; c++) begin
        for (int i = D + 1; i > 0; i--) win[c][i] = win[c][i-1];
        win[c][0] = raw[c];
        all_diff = 1'b1;
        for (int i = 2; i < D + 2; i++) if (win[c][i] == st[c]) all_diff = 1'b0;
        if (all_diff) begin
          st[c] = !st[c];
          if (c == 2) drop_pend = st[c];
          else if (st[c]) begin
            held[c] = 1'b1; first[c] = 1'b1; nxt[c] = mt + 1;
          end else held[c] = 1'b0;
        end
      end
      exp_d = sd;
      exp_r = sr && !sd && !sl;
      exp_l = sl && !sd && !sr;
    end
  end

  always @(negedge clk) begin
    if (move_right === 1'b1) q_r.push_back(cyc);
    if (move_left  === 1'b1) q_l.push_back(cyc);
    if (drop_piece === 1'b1) q_d.push_back(cyc);
    check("model_right", int'(move_right), int'(exp_r));
    check("model_left",  int'(move_left),  int'(exp_l));
    check("model_drop",  int'(drop_piece), int'(exp_d));
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int k, e0, f;

    // Buttons held through reset must not leak out.
    raw = 3'b111;
    cycles(6);
    check("rst_right", int'(move_right), 0);
    check("rst_left",  int'(move_left),  0);
    check("rst_drop",  int'(drop_piece), 0);
    raw = 3'b000;
    cycles(2);
    rst_n = 1'b1;
    cycles(10);

    // Clean drop press.
    q_d.delete();
    raw[2] = 1'b1; k = cyc + 1;
    cycles(15);
    check("drop_count", q_d.size(), 1);
    check("drop_latency", q_d.size() > 0 ? q_d[0] - k : -1, D + 2);
    raw[2] = 1'b0;
    cycles(12);

    // Bouncing left, then held.
    q_l.delete();
    for (int i = 0; i < 5; i++) begin
      raw[1] = 1'b1; cycles(3);
      raw[1] = 1'b0; cycles(1);
    end
    raw[1] = 1'b1; f = cyc + 1;
    cycles(12);
    check("bounce_count", q_l.size(), 1);
    check("bounce_latency", q_l.size() > 0 ? q_l[0] - f : -1, D + 2);
    raw[1] = 1'b0;
    cycles(12);

    // Auto-repeat on right; release event lands at offset 71.
    q_r.delete();
    raw[0] = 1'b1; k = cyc + 1; e0 = k + D + 2;
    wait_until(e0 + 65);
    raw[0] = 1'b0;
    cycles(40);
    check("repeat_count", q_r.size(), 8);
    for (int i = 0; i < 8; i++)
      check("repeat_offset", i < q_r.size() ? q_r[i] - e0 : -1, i == 0 ? 0 : RD + RR * (i - 1));

    // Left released before the first repeat (release event at offset 15).
    q_l.delete();
    raw[1] = 1'b1; k = cyc + 1; e0 = k + D + 2;
    wait_until(e0 + 9);
    raw[1] = 1'b0;
    cycles(40);
    check("early_rel_count", q_l.size(), 1);
    check("early_rel_offset", q_l.size() > 0 ? q_l[0] - e0 : -1, 0);

    // Left and right together cancel.
    q_l.delete(); q_r.delete();
    raw[1:0] = 2'b11;
    cycles(14);
    check("cancel_right", q_r.size(), 0);
    check("cancel_left",  q_l.size(), 0);
    raw[1:0] = 2'b00;
    cycles(12);

    // Drop beats right.
    q_d.delete(); q_r.delete();
    raw[2] = 1'b1; raw[0] = 1'b1;
    cycles(14);
    check("prio_drop",  q_d.size(), 1);
    check("prio_right", q_r.size(), 0);
    raw[2] = 1'b0; raw[0] = 1'b0;
    cycles(12);

    // Reset in REPEAT while right is held.
    raw[0] = 1'b1; k = cyc + 1; e0 = k + D + 2;
    wait_until(e0 + RD + RR);
    check("pre_reset_right", int'(move_right), 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_right", int'(move_right), 0);
    cycles(3);
    rst_n = 1'b1; k = cyc + 1; q_r.delete();
    cycles(30);
    check("post_reset_count", q_r.size(), 2);
    check("post_reset_first",  q_r.size() > 0 ? q_r[0] - k : -1, D + 2);
    check("post_reset_repeat", q_r.size() > 1 ? q_r[1] - k : -1, D + 2 + RD);
    raw[0] = 1'b0;
    cycles(15);

    // Random button activity against the model, with one reset mid-way.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(29) == 0) raw[0] = ~raw[0];
      if ($urandom_range(29) == 0) raw[1] = ~raw[1];
      if ($urandom_range(9)  == 0) raw[2] = ~raw[2];
      if (i == 1000) begin
        #3 rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
      end
      cycles(1);
    end
    raw = 3'b000;
    cycles(20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
